// File: rtl/misr_signature_checker.sv
// misr_signature_checker
//
// Response-compaction end of the logic-BIST path. Responses from the unit
// under test are folded into a Multiple-Input Signature Register (MISR) for
// a programmed number of accepts. The final signature is then compared
// against a golden value, and busy/done/pass/fail are reported to the BIST
// controller.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle pulse, begins a session from IDLE or DONE
//   abort          synchronous return to IDLE, beats start and accepts
//   pattern_count  number of responses to compact, latched on start
//   golden_sig     expected signature, latched on start
//   resp_valid     response word valid
//   resp_data      response word from the unit under test
//   resp_ready     high while compacting (RUN)
//   busy           high in RUN and CHECK
//   done           high in DONE
//   pass / fail    comparison result, meaningful while done is high
//   signature      live MISR contents
module misr_signature_checker #(
   parameter int                 WIDTH       = 32,
   parameter logic [WIDTH-1:0]   TAP_MASK    = 32'h8020_0003,
   parameter logic [WIDTH-1:0]   INITIAL_SIG = 32'hFFFF_FFFF,
   parameter int                 CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CNT_WIDTH-1:0] pattern_count,
   input  logic [WIDTH-1:0]     golden_sig,
   input  logic                 resp_valid,
   input  logic [WIDTH-1:0]     resp_data,
   output logic                 resp_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic [WIDTH-1:0]     signature
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } stateT;

   stateT                state;
   stateT                nextState;
   logic [WIDTH-1:0]     sigReg;
   logic [WIDTH-1:0]     sigNext;
   logic                 feedback;
   logic [CNT_WIDTH-1:0] respCount;
   logic [CNT_WIDTH-1:0] countNext;
   logic [CNT_WIDTH-1:0] latchedCount;
   logic [WIDTH-1:0]     latchedGolden;
   logic                 passReg;
   logic                 failReg;
   logic                 startOk;
   logic                 accept;
   logic                 lastAccept;

   // Qualify the control inputs. A start only counts when we are idle or
   // parked on a result, and abort suppresses both a start and an accept in
   // the same cycle. The MISR step shifts left, feeds the tap parity into bit
   // 0 and XORs in the incoming response word.
   always_comb begin
      startOk    = start && !abort && ((state == IDLE) || (state == DONE));
      accept     = (state == RUN) && resp_valid && !abort;
      countNext  = respCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      lastAccept = accept && (countNext == latchedCount);
      feedback   = ^(sigReg & TAP_MASK);
      sigNext    = {sigReg[WIDTH-2:0], feedback} ^ resp_data;
   end

   // State register for the session FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and status decode. CHECK lasts exactly one cycle while the
   // comparison is registered. A zero-length session skips RUN and goes
   // straight to CHECK, which compares the freshly loaded seed. Abort
   // overrides every other transition.
   always_comb begin
      nextState  = state;
      resp_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (startOk) begin
               nextState = (pattern_count == '0) ? CHECK : RUN;
            end
         end
         RUN: begin
            resp_ready = 1'b1;
            busy       = 1'b1;
            if (lastAccept) begin
               nextState = CHECK;
            end
         end
         CHECK: begin
            busy      = 1'b1;
            nextState = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (startOk) begin
               nextState = (pattern_count == '0) ? CHECK : RUN;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
      if (abort) begin
         nextState = IDLE;
      end
   end

   // Datapath registers. Abort clears the counter and the result but leaves
   // the signature alone so it can be inspected after a failed session. A
   // start reseeds the MISR and captures the session parameters, so later
   // changes on pattern_count and golden_sig cannot disturb a running
   // session. The result flags are written only in CHECK, which makes them
   // mutually exclusive and zero whenever done is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sigReg        <= INITIAL_SIG;
         respCount     <= '0;
         latchedCount  <= '0;
         latchedGolden <= '0;
         passReg       <= 1'b0;
         failReg       <= 1'b0;
      end else if (abort) begin
         respCount <= '0;
         passReg   <= 1'b0;
         failReg   <= 1'b0;
      end else if (startOk) begin
         sigReg        <= INITIAL_SIG;
         respCount     <= '0;
         latchedCount  <= pattern_count;
         latchedGolden <= golden_sig;
         passReg       <= 1'b0;
         failReg       <= 1'b0;
      end else if (accept) begin
         sigReg    <= sigNext;
         respCount <= countNext;
      end else if (state == CHECK) begin
         passReg <= (sigReg == latchedGolden);
         failReg <= (sigReg != latchedGolden);
      end
   end

   // Drive the result and signature outputs straight from their registers.
   always_comb begin
      pass      = passReg;
      fail      = failReg;
      signature = sigReg;
   end

endmodule

// File: tb/tb_misr_signature_checker.sv
// tb_misr_signature_checker
//
// Directed self-checking bench for misr_signature_checker. It drives inputs
// one time unit after each rising edge and samples outputs at that same
// point. Expected signatures are worked out by hand from the MISR step
// (x^32+x^22+x^2+x^1+1, seed 0xFFFF_FFFF).
module tb_misr_signature_checker;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] pattern_count;
   logic [31:0] golden_sig;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_ready;
   logic        busy;
   logic        done;
   logic        pass;
   logic        fail;
   logic [31:0] signature;

   int checkCount;
   int passCount;
   int failCount;

   misr_signature_checker dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .pattern_count (pattern_count),
      .golden_sig    (golden_sig),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .resp_ready    (resp_ready),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .fail          (fail),
      .signature     (signature)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stop a runaway simulation after a generous time limit.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // Single comparison point. Every check counts here, and any mismatch is
   // reported with the observed and expected values.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of the control and response inputs, then release the
   // pulses.
   task automatic applyStimulus(input logic doStart, input logic doAbort,
                                input logic [15:0] cnt, input logic [31:0] gold,
                                input logic valid, input logic [31:0] data);
      start         = doStart;
      abort         = doAbort;
      pattern_count = cnt;
      golden_sig    = gold;
      resp_valid    = valid;
      resp_data     = data;
      tick();
      start      = 1'b0;
      abort      = 1'b0;
      resp_valid = 1'b0;
   endtask

   initial begin
      checkCount    = 0;
      passCount     = 0;
      failCount     = 0;
      rst           = 1'b1;
      start         = 1'b0;
      abort         = 1'b0;
      pattern_count = '0;
      golden_sig    = '0;
      resp_valid    = 1'b0;
      resp_data     = '0;

      // Reset state
      tick();
      tick();
      checkOutput("reset_sig", signature, 32'hFFFF_FFFF);
      checkOutput("reset_ready", {31'd0, resp_ready}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_passfail", {30'd0, pass, fail}, 32'd0);
      rst = 1'b0;
      tick();

      // Single zero response, expected to pass
      applyStimulus(1'b1, 1'b0, 16'd1, 32'hFFFF_FFFE, 1'b0, 32'h0);
      checkOutput("t1_run_ready", {31'd0, resp_ready}, 32'd1);
      checkOutput("t1_run_busy", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0, 1'b0, 16'd1, 32'hFFFF_FFFE, 1'b1, 32'h0);
      checkOutput("t1_sig", signature, 32'hFFFF_FFFE);
      checkOutput("t1_check_ready", {31'd0, resp_ready}, 32'd0);
      checkOutput("t1_check_done", {31'd0, done}, 32'd0);
      checkOutput("t1_check_busy", {31'd0, busy}, 32'd1);
      tick();
      checkOutput("t1_done", {31'd0, done}, 32'd1);
      checkOutput("t1_passfail", {30'd0, pass, fail}, 32'b10);
      checkOutput("t1_busy_low", {31'd0, busy}, 32'd0);
      tick();
      checkOutput("t1_done_hold", {29'd0, done, pass, fail}, 32'b110);

      // Single one response, expected to fail
      applyStimulus(1'b1, 1'b0, 16'd1, 32'hFFFF_FFFE, 1'b0, 32'h0);
      checkOutput("t2_reseed", signature, 32'hFFFF_FFFF);
      checkOutput("t2_cleared", {29'd0, done, pass, fail}, 32'd0);
      applyStimulus(1'b0, 1'b0, 16'd1, 32'hFFFF_FFFE, 1'b1, 32'h1);
      tick();
      checkOutput("t2_sig", signature, 32'hFFFF_FFFF);
      checkOutput("t2_result", {29'd0, done, pass, fail}, 32'b101);

      // Zero-length session
      applyStimulus(1'b1, 1'b0, 16'd0, 32'hFFFF_FFFF, 1'b0, 32'h0);
      checkOutput("t3_check_ready", {31'd0, resp_ready}, 32'd0);
      checkOutput("t3_check_busy", {31'd0, busy}, 32'd1);
      checkOutput("t3_check_done", {31'd0, done}, 32'd0);
      tick();
      checkOutput("t3_result", {29'd0, done, pass, fail}, 32'b110);
      checkOutput("t3_sig", signature, 32'hFFFF_FFFF);

      // Backpressure gaps; inputs scrambled after start must not matter
      applyStimulus(1'b1, 1'b0, 16'd3, 32'hFFFF_FFFB, 1'b0, 32'h0);
      pattern_count = 16'd1;
      golden_sig    = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         resp_valid = 1'b1;
         resp_data  = 32'h0;
         tick();
         resp_valid = 1'b0;
         resp_data  = 32'hDEAD_BEEF;
         if (i == 0) begin
            checkOutput("t4_first_sig", signature, 32'hFFFF_FFFE);
         end
         if (i < 2) begin
            for (int g = 0; g < 2; g++) begin
               tick();
               checkOutput("t4_gap_busy", {31'd0, busy}, 32'd1);
               checkOutput("t4_gap_ready", {31'd0, resp_ready}, 32'd1);
            end
         end
      end
      checkOutput("t4_final_sig", signature, 32'hFFFF_FFFB);
      checkOutput("t4_check_busy", {31'd0, busy}, 32'd1);
      tick();
      checkOutput("t4_result", {29'd0, done, pass, fail}, 32'b110);

      // Abort with simultaneous start and valid response after two accepts
      applyStimulus(1'b1, 1'b0, 16'd4, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 16'd4, 32'h0, 1'b1, 32'h0);
      applyStimulus(1'b0, 1'b0, 16'd4, 32'h0, 1'b1, 32'h0);
      checkOutput("t5_two_sig", signature, 32'hFFFF_FFFD);
      applyStimulus(1'b1, 1'b1, 16'd4, 32'h0, 1'b1, 32'h0);
      checkOutput("t5_abort_status", {28'd0, busy, done, pass, fail}, 32'd0);
      checkOutput("t5_abort_ready", {31'd0, resp_ready}, 32'd0);
      checkOutput("t5_abort_sig", signature, 32'hFFFF_FFFD);
      tick();
      checkOutput("t5_idle_hold", {28'd0, busy, done, pass, fail}, 32'd0);
      applyStimulus(1'b1, 1'b0, 16'd1, 32'hFFFF_FFFE, 1'b0, 32'h0);
      checkOutput("t5_reseed", signature, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 1'b0, 16'd1, 32'hFFFF_FFFE, 1'b1, 32'h0);
      tick();
      checkOutput("t5_rerun_result", {29'd0, done, pass, fail}, 32'b110);

      // Asynchronous reset between edges during RUN
      applyStimulus(1'b1, 1'b0, 16'd4, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 16'd4, 32'h0, 1'b1, 32'h0);
      checkOutput("t6_pre_sig", signature, 32'hFFFF_FFFE);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_async_ready", {31'd0, resp_ready}, 32'd0);
      checkOutput("t6_async_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_async_sig", signature, 32'hFFFF_FFFF);
      checkOutput("t6_async_flags", {29'd0, done, pass, fail}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("t6_idle_after", {28'd0, busy, done, pass, fail}, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/misr_signature_checker.md
Name: misr_signature_checker

Overview:
- Response-compaction end of the logic-BIST path. The LFSR pattern generator drives stimulus into the unit under test; this block consumes the unit's responses.
- It folds a programmed number of responses into a Multiple-Input Signature Register (MISR) and compares the final signature against a golden value.
- It reports busy, done and pass/fail to the BIST controller.

Parameters:
- WIDTH, 32, response and signature width in bits.
- TAP_MASK, 32'h8020_0003, feedback taps: x^32+x^22+x^2+x^1+1, bits 31/21/1/0. Same polynomial as the pattern generator.
- INITIAL_SIG, 32'hFFFF_FFFF, MISR value loaded on reset and on start.
- CNT_WIDTH, 16, width of the response counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a session when state is IDLE or DONE.
- abort  in  1  synchronous; returns the block to IDLE from any state.
- pattern_count  in  CNT_WIDTH  number of responses to compact; sampled on an accepted start.
- golden_sig  in  WIDTH  expected signature; sampled on an accepted start.
- resp_valid  in  1  response data valid.
- resp_data  in  WIDTH  response word from the unit under test.
- resp_ready  out  1  high in RUN; a response is accepted when resp_valid && resp_ready.
- busy  out  1  high in RUN and CHECK.
- done  out  1  high in DONE.
- pass  out  1  signature matched golden; valid while done=1.
- fail  out  1  signature mismatched golden; valid while done=1.
- signature  out  WIDTH  current MISR contents, live in every state.

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous, active-high.
- Reset values: state=IDLE, signature=INITIAL_SIG, counter=0, resp_ready=0, busy=0, done=0, pass=0, fail=0. The latched count and golden registers reset to 0.
- MISR update on each accepted response: fb = ^(sig & TAP_MASK); sig_next = {sig[WIDTH-2:0], fb} ^ resp_data.
- The signature changes only on accepted responses and on start/reset loads.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE/DONE + start (abort low):
  - load sig=INITIAL_SIG, counter=0;
  - latch pattern_count and golden_sig;
  - clear done, pass, fail;
  - go to RUN, or to CHECK if pattern_count==0.
- RUN:
  - resp_ready=1; each accepted response updates the MISR and increments the counter;
  - the accept that makes counter == latched count moves the FSM to CHECK;
  - resp_valid low: hold state, no update;
  - start is ignored.
- CHECK: exactly one cycle, resp_ready=0. Registers pass = (sig == golden) and fail = its complement, sets done, then moves to DONE.
- DONE: done, pass, fail and signature held until start or abort.
- Latency: final accept at edge N puts the FSM in CHECK; done/pass/fail are visible after edge N+1.
- Zero-count session: start at edge N gives CHECK; done after edge N+1, and signature=INITIAL_SIG is compared.
- Counter width: no wrap is needed. The count equals the latched pattern_count, at most 2^CNT_WIDTH-1.
- abort has priority over start and over response acceptance in the same cycle:
  - go to IDLE; clear done, pass, fail, counter;
  - signature keeps its current value, for debug.
- start and abort together: abort wins and the FSM ends in IDLE.
- rst asserted mid-session: immediate return to all reset values. No partial result survives.
- pass and fail are never both high. Both are 0 whenever done=0.
- golden_sig and pattern_count changing after start have no effect on the running session.

Test Plan:
- Single zero response: reset, start with count=1, golden=0xFFFF_FFFE, one resp_data=0x0000_0000.
  -> signature=0xFFFF_FFFE, done 1 cycle after the accept, pass=1, fail=0.
- Single one response: same setup, resp_data=0x0000_0001, golden=0xFFFF_FFFE.
  -> signature=0xFFFF_FFFF, fail=1, pass=0.
- Zero count: start with count=0, golden=0xFFFF_FFFF.
  -> no resp_ready pulse, done after 2 edges, pass=1.
- Backpressure gaps: count=3, responses 0, 0, 0 with resp_valid low for 2 cycles between each.
  -> only 3 accepts; after the first, signature=0xFFFF_FFFE; the result matches a reference model and busy stays high throughout.
- Abort mid-run: count=4, abort after 2 accepts, start asserted in the same cycle.
  -> IDLE, done=0, pass=0, fail=0, counter=0, signature holds its 2-accept value.
  - A later start re-seeds the signature to 0xFFFF_FFFF.
- Async reset mid-run: rst pulsed between clock edges in RUN.
  -> all outputs reach reset values immediately; resp_ready=0 before the next edge.
